// File: rtl/cpm_stream_checker.sv
// Passive protocol checker and statistics block for one CPM valid/ready stream.
// Flags stall-obligation and liveness violations and counts handshakes and stalls.
module cpm_stream_checker #(
    parameter int ID_W           = 4,
    parameter int OP_W           = 4,
    parameter int PAYLOAD_W      = 16,
    parameter int LIVENESS_BOUND = 16,
    parameter int CNT_W          = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 valid,
    input  logic                 ready,
    input  logic [ID_W-1:0]      id,
    input  logic [OP_W-1:0]      opcode,
    input  logic [PAYLOAD_W-1:0] payload,
    output logic                 err_valid_drop,
    output logic                 err_data_change,
    output logic                 err_liveness,
    output logic [2:0]           err_sticky,
    output logic [1:0]           first_err_code,
    output logic [ID_W-1:0]      first_err_id,
    output logic [CNT_W-1:0]     hs_count,
    output logic [CNT_W-1:0]     stall_events,
    output logic [CNT_W-1:0]     max_stall
);

    typedef enum logic [1:0] {IDLE, STALL, TIMEOUT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] LEN_TO  = CNT_W'(LIVENESS_BOUND + 1);

    state_t               state, state_nxt;
    logic [ID_W-1:0]      snap_id;
    logic [OP_W-1:0]      snap_op;
    logic [PAYLOAD_W-1:0] snap_pl;
    logic [CNT_W-1:0]     len, len_nxt, len_inc;

    logic stall_s, hs_s, in_ep, diff, start;
    logic det_vd, det_dc, det_lv;
    logic [2:0]      sticky_base;
    logic [1:0]      code_base, code_nxt;
    logic [ID_W-1:0] fid_base, fid_nxt;

    always_comb begin
        stall_s = valid & ~ready;
        hs_s    = valid & ready;
        in_ep   = (state != IDLE);
        diff    = ({id, opcode, payload} != {snap_id, snap_op, snap_pl});
        start   = en & ~in_ep & stall_s;
        len_inc = (len == CNT_MAX) ? len : len + 1'b1;
        det_vd  = en & in_ep & ~valid;
        det_dc  = en & in_ep & valid & diff;
        det_lv  = en & (state == STALL) & stall_s & (len_inc == LEN_TO);
    end

    always_comb begin
        state_nxt = state;
        len_nxt   = len;
        if (!en) begin
            state_nxt = IDLE;
            len_nxt   = '0;
        end else if (!in_ep) begin
            state_nxt = start ? STALL : IDLE;
            len_nxt   = start ? CNT_W'(1) : '0;
        end else if (!valid || ready) begin
            state_nxt = IDLE;
            len_nxt   = '0;
        end else begin
            state_nxt = det_lv ? TIMEOUT : state;
            len_nxt   = len_inc;
        end
    end

    // clear applies first so a coincident violation is still recorded
    always_comb begin
        sticky_base = clr ? 3'b000 : err_sticky;
        code_base   = clr ? 2'd0 : first_err_code;
        fid_base    = clr ? '0 : first_err_id;
        code_nxt    = code_base;
        fid_nxt     = fid_base;
        if (code_base == 2'd0) begin
            if (det_vd) begin
                code_nxt = 2'd1;
                fid_nxt  = snap_id;
            end else if (det_dc) begin
                code_nxt = 2'd2;
                fid_nxt  = snap_id;
            end else if (det_lv) begin
                code_nxt = 2'd3;
                fid_nxt  = snap_id;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            len             <= '0;
            snap_id         <= '0;
            snap_op         <= '0;
            snap_pl         <= '0;
            err_valid_drop  <= 1'b0;
            err_data_change <= 1'b0;
            err_liveness    <= 1'b0;
            err_sticky      <= 3'b000;
            first_err_code  <= 2'd0;
            first_err_id    <= '0;
            hs_count        <= '0;
            stall_events    <= '0;
            max_stall       <= '0;
        end else begin
            state           <= state_nxt;
            len             <= len_nxt;
            err_valid_drop  <= det_vd;
            err_data_change <= det_dc;
            err_liveness    <= det_lv;
            err_sticky      <= sticky_base | {det_lv, det_dc, det_vd};
            first_err_code  <= code_nxt;
            first_err_id    <= fid_nxt;
            if (start || det_dc) begin
                snap_id <= id;
                snap_op <= opcode;
                snap_pl <= payload;
            end
            if (clr) begin
                hs_count     <= '0;
                stall_events <= '0;
                max_stall    <= '0;
            end else begin
                if (en && hs_s && hs_count != CNT_MAX)
                    hs_count <= hs_count + 1'b1;
                if (start && stall_events != CNT_MAX)
                    stall_events <= stall_events + 1'b1;
                if (len_nxt > max_stall)
                    max_stall <= len_nxt;
            end
        end
    end

endmodule

// File: tb/tb_cpm_stream_checker.sv
// Bench for cpm_stream_checker: directed scenarios plus randomized traffic
// compared every cycle against an episode-level reference model.
module tb_cpm_stream_checker;

    localparam int BOUND = 16;

    logic        clk = 1'b0;
    logic        rst, en, clr, valid, ready;
    logic [3:0]  id, opcode;
    logic [15:0] payload;
    logic        err_valid_drop, err_data_change, err_liveness;
    logic [2:0]  err_sticky;
    logic [1:0]  first_err_code;
    logic [3:0]  first_err_id;
    logic [31:0] hs_count, stall_events, max_stall;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    always #5 clk = ~clk;

    cpm_stream_checker #(
        .ID_W(4), .OP_W(4), .PAYLOAD_W(16),
        .LIVENESS_BOUND(BOUND), .CNT_W(32)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .valid(valid), .ready(ready),
        .id(id), .opcode(opcode), .payload(payload),
        .err_valid_drop(err_valid_drop),
        .err_data_change(err_data_change),
        .err_liveness(err_liveness),
        .err_sticky(err_sticky),
        .first_err_code(first_err_code),
        .first_err_id(first_err_id),
        .hs_count(hs_count),
        .stall_events(stall_events),
        .max_stall(max_stall)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks the open episode as a plain sample count.
    bit          m_ep, m_to;
    int          m_cnt, m_hs, m_se, m_max;
    logic [3:0]  s_id, s_op;
    logic [15:0] s_pl;
    bit          m_vd, m_dc, m_lv;
    bit [2:0]    m_sticky;
    int          m_code;
    logic [3:0]  m_fid;

    always @(posedge clk) begin
        bit vd, dc, lv;
        logic [3:0] old_id;
        vd = 0; dc = 0; lv = 0;
        old_id = s_id;
        if (rst) begin
            m_ep = 0; m_to = 0; m_cnt = 0; m_hs = 0; m_se = 0; m_max = 0;
            s_id = 0; s_op = 0; s_pl = 0;
            m_sticky = 0; m_code = 0; m_fid = 0;
        end else begin
            if (clr) begin
                m_sticky = 0; m_code = 0; m_fid = 0;
            end
            if (!en) begin
                m_ep = 0; m_cnt = 0;
            end else if (m_ep) begin
                if (!valid) begin
                    vd = 1; m_ep = 0; m_cnt = 0;
                end else begin
                    if ({id, opcode, payload} != {s_id, s_op, s_pl}) begin
                        dc = 1;
                        s_id = id; s_op = opcode; s_pl = payload;
                    end
                    if (ready) begin
                        m_ep = 0; m_cnt = 0;
                    end else begin
                        m_cnt++;
                        if (m_cnt == BOUND + 1 && !m_to) begin
                            lv = 1; m_to = 1;
                        end
                    end
                end
            end else if (valid && !ready) begin
                m_ep = 1; m_to = 0; m_cnt = 1;
                s_id = id; s_op = opcode; s_pl = payload;
                if (!clr) m_se++;
            end
            if (clr) begin
                m_hs = 0; m_se = 0; m_max = 0;
            end else begin
                if (en && valid && ready) m_hs++;
                if (m_cnt > m_max) m_max = m_cnt;
            end
            if (m_code == 0) begin
                if (vd) m_code = 1;
                else if (dc) m_code = 2;
                else if (lv) m_code = 3;
                if (m_code != 0) m_fid = old_id;
            end
            m_sticky = m_sticky | {lv, dc, vd};
        end
        m_vd = vd; m_dc = dc; m_lv = lv;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("valid_drop", err_valid_drop, m_vd);
            chk("data_change", err_data_change, m_dc);
            chk("liveness", err_liveness, m_lv);
            chk("sticky", err_sticky, m_sticky);
            chk("code", first_err_code, m_code);
            chk("first_id", first_err_id, m_fid);
            chk("hs_count", hs_count, m_hs);
            chk("stall_events", stall_events, m_se);
            chk("max_stall", max_stall, m_max);
        end
    end

    task automatic drv(input bit r, input bit e, input bit c, input bit v,
                       input bit rd, input logic [3:0] i,
                       input logic [15:0] p);
        rst = r; en = e; clr = c; valid = v; ready = rd;
        id = i; opcode = 4'h7; payload = p;
        @(negedge clk);
    endtask

    int lv_n, lv_at;
    logic [3:0]  r_id;
    logic [15:0] r_pl;

    initial begin
        rst = 1; en = 1; clr = 0; valid = 0; ready = 0;
        id = 0; opcode = 0; payload = 0;
        repeat (2) @(negedge clk);
        started = 1;
        drv(1, 1, 0, 0, 0, 0, 0);
        chk("rst_sticky", err_sticky, 0);
        chk("rst_hs", hs_count, 0);
        chk("rst_max", max_stall, 0);

        repeat (10) drv(0, 1, 0, 1, 1, 1, 16'h1);
        chk("hs10", hs_count, 10);
        chk("hs10_sticky", err_sticky, 0);
        chk("hs10_code", first_err_code, 0);
        chk("hs10_se", stall_events, 0);

        repeat (5) drv(0, 1, 0, 1, 0, 3, 16'hBEEF);
        drv(0, 1, 0, 1, 1, 3, 16'hBEEF);
        chk("stall5_se", stall_events, 1);
        chk("stall5_max", max_stall, 5);
        chk("stall5_sticky", err_sticky, 0);

        drv(0, 1, 0, 1, 0, 5, 16'h1234);
        drv(0, 1, 0, 0, 0, 5, 16'h1234);
        chk("vd_pulse", err_valid_drop, 1);
        chk("vd_sticky", err_sticky, 3'b001);
        chk("vd_code", first_err_code, 1);
        chk("vd_id", first_err_id, 5);
        drv(0, 1, 0, 0, 0, 0, 0);
        chk("vd_pulse_end", err_valid_drop, 0);

        drv(0, 1, 1, 0, 0, 0, 0);
        drv(0, 1, 0, 1, 0, 6, 16'hBEEF);
        drv(0, 1, 0, 1, 0, 6, 16'hBEF0);
        chk("dc_pulse", err_data_change, 1);
        chk("dc_code", first_err_code, 2);
        drv(0, 1, 0, 0, 0, 6, 16'hBEF0);
        chk("dc_vd_sticky", err_sticky, 3'b011);
        chk("dc_vd_code", first_err_code, 2);

        drv(0, 1, 1, 0, 0, 0, 0);
        repeat (16) drv(0, 1, 0, 1, 0, 2, 16'h55);
        drv(0, 1, 0, 1, 1, 2, 16'h55);
        chk("bound16_sticky", err_sticky, 0);
        lv_n = 0; lv_at = 0;
        for (int k = 1; k <= 40; k++) begin
            drv(0, 1, 0, 1, 0, 9, 16'h66);
            if (err_liveness) begin
                lv_n++;
                lv_at = k;
            end
        end
        drv(0, 1, 0, 1, 1, 9, 16'h66);
        chk("lv_count", lv_n, 1);
        chk("lv_at", lv_at, 17);
        chk("lv_max", max_stall, 40);
        chk("lv_code", first_err_code, 3);
        chk("lv_id", first_err_id, 9);

        repeat (2) drv(0, 1, 0, 1, 0, 4, 16'h77);
        drv(0, 1, 1, 1, 0, 4, 16'h77);
        chk("clr_hs", hs_count, 0);
        chk("clr_se", stall_events, 0);
        chk("clr_max", max_stall, 0);
        chk("clr_sticky", err_sticky, 0);
        drv(0, 1, 0, 1, 0, 4, 16'h77);
        drv(0, 1, 0, 1, 1, 4, 16'h77);
        chk("clr_keep_max", max_stall, 4);
        chk("clr_keep_se", stall_events, 0);

        repeat (2) drv(0, 1, 0, 1, 0, 8, 16'h88);
        drv(1, 1, 0, 1, 0, 8, 16'h88);
        chk("rst_mid_max", max_stall, 0);
        chk("rst_mid_se", stall_events, 0);
        drv(0, 1, 0, 0, 0, 8, 16'h88);
        chk("rst_rel_vd", err_valid_drop, 0);
        chk("rst_rel_sticky", err_sticky, 0);

        r_id = 0; r_pl = 0;
        for (int n = 0; n < 4000; n++) begin
            automatic int rdy_pct = ((n / 400) % 2 == 0) ? 50 : 8;
            if ($urandom_range(99) < 10) begin
                r_id = 4'($urandom_range(15));
                r_pl = 16'($urandom_range(3));
            end
            drv($urandom_range(999) < 2,
                $urandom_range(99) < 95,
                $urandom_range(99) < 2,
                $urandom_range(99) < 85,
                $urandom_range(99) < rdy_pct,
                r_id, r_pl);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
